// File: rtl/stage2_message_scheduler.sv
// Round-robin scheduler producing message_number_control for the stage-2 lookup.
// Per-source saturating request counters feed a registered valid/ready issue port.
module stage2_message_scheduler #(
  parameter int CTRL_W  = 2,
  parameter int NUM_REQ = 2 ** CTRL_W,
  parameter int CNT_W   = 4,
  parameter int SEQ_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic [CTRL_W-1:0]  message_number_control,
  output logic               issue_valid,
  output logic [SEQ_W-1:0]   issue_seq,
  output logic [NUM_REQ-1:0] pend_overflow,
  output logic               busy
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REQ];
  logic [CNT_W-1:0]    cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0]  ovf_q, ovf_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [CTRL_W-1:0]   last_q, last_d;
  logic                valid_q, valid_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;

  logic                accept;
  logic [NUM_REQ-1:0]  dec_hit;
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  nonzero;
  logic [CTRL_W-1:0]   base;
  logic [CTRL_W-1:0]   winner;
  logic                found;

  assign accept = valid_q & ready;

  // A source being accepted this cycle only stays a candidate if it has more pending.
  always_comb begin
    dec_hit = '0;
    cand    = '0;
    nonzero = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dec_hit[i] = accept && (ctrl_q == CTRL_W'(i));
      nonzero[i] = (cnt_q[i] != '0);
      cand[i]    = nonzero[i] && !(dec_hit[i] && (cnt_q[i] == CNT_W'(1)));
    end
  end

  // Search starts after the grant that takes effect this cycle.
  always_comb begin
    base   = accept ? ctrl_q : last_q;
    winner = base;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && cand[CTRL_W'(32'(base) + k)]) begin
        winner = CTRL_W'(32'(base) + k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req[i] && !dec_hit[i]) begin
        if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
        else                cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_hit[i] && !req[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    last_d  = last_q;
    valid_d = valid_q;
    seq_d   = seq_q;
    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          ctrl_d  = winner;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          last_d = ctrl_q;
          seq_d  = seq_q + SEQ_W'(1);
          if (enable && found) begin
            ctrl_d = winner;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '{default: '0};
      ovf_q   <= '0;
      ctrl_q  <= '0;
      last_q  <= CTRL_W'(NUM_REQ - 1);
      valid_q <= 1'b0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ctrl_q  <= ctrl_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
    end
  end

  assign message_number_control = ctrl_q;
  assign issue_valid            = valid_q;
  assign issue_seq              = seq_q;
  assign pend_overflow          = ovf_q;
  assign busy                   = valid_q | (|nonzero);

endmodule

// File: tb/tb_stage2_message_scheduler.sv
// Directed bench for stage2_message_scheduler; outputs sampled on the falling edge.
module tb_stage2_message_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req;
  logic        ready;
  logic [1:0]  message_number_control;
  logic        issue_valid;
  logic [15:0] issue_seq;
  logic [3:0]  pend_overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage2_message_scheduler #(
    .CTRL_W (2),
    .NUM_REQ(4),
    .CNT_W  (4),
    .SEQ_W  (16)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .req                   (req),
    .ready                 (ready),
    .message_number_control(message_number_control),
    .issue_valid           (issue_valid),
    .issue_seq             (issue_seq),
    .pend_overflow         (pend_overflow),
    .busy                  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  int n_acc;
  int exp_seq;
  bit done;

  initial begin
    rst = 1'b1; enable = 1'b1; ready = 1'b1; req = '0;

    // Single request on source 2
    do_reset();
    check("rst_valid", 32'(issue_valid), 0);
    check("rst_ctrl", 32'(message_number_control), 0);
    check("rst_seq", 32'(issue_seq), 0);
    check("rst_ovf", 32'(pend_overflow), 0);
    check("rst_busy", 32'(busy), 0);
    req = 4'b0100;
    cyc(); req = '0;
    check("t1_busy_cnt", 32'(busy), 1);
    check("t1_not_yet", 32'(issue_valid), 0);
    cyc();
    check("t1_valid", 32'(issue_valid), 1);
    check("t1_ctrl", 32'(message_number_control), 2);
    check("t1_seq", 32'(issue_seq), 0);
    cyc();
    check("t1_done", 32'(issue_valid), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_seq_after", 32'(issue_seq), 1);

    // All four sources at once
    do_reset();
    req = 4'b1111;
    cyc(); req = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t2_valid", 32'(issue_valid), 1);
      check("t2_ctrl", 32'(message_number_control), 32'(k));
      check("t2_seq", 32'(issue_seq), 32'(k));
    end
    cyc();
    check("t2_idle", 32'(issue_valid), 0);
    check("t2_busy", 32'(busy), 0);

    // Backpressure holds the issue; then back-to-back drain
    do_reset();
    ready = 1'b0;
    req = 4'b0010;
    cyc(); cyc(); cyc();
    req = '0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("t3_hold_valid", 32'(issue_valid), 1);
      check("t3_hold_ctrl", 32'(message_number_control), 1);
      check("t3_hold_seq", 32'(issue_seq), 0);
    end
    ready = 1'b1;
    cyc();
    check("t3_b2b1_valid", 32'(issue_valid), 1);
    check("t3_b2b1_ctrl", 32'(message_number_control), 1);
    check("t3_b2b1_seq", 32'(issue_seq), 1);
    cyc();
    check("t3_b2b2_valid", 32'(issue_valid), 1);
    check("t3_b2b2_seq", 32'(issue_seq), 2);
    cyc();
    check("t3_end_valid", 32'(issue_valid), 0);
    check("t3_end_seq", 32'(issue_seq), 3);

    // Saturation and sticky overflow
    do_reset();
    ready = 1'b0;
    req = 4'b0001;
    for (int k = 0; k < 20; k++) cyc();
    req = '0;
    check("t4_ovf", 32'(pend_overflow), 32'h1);
    check("t4_valid", 32'(issue_valid), 1);
    check("t4_ctrl", 32'(message_number_control), 0);
    ready = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 40; k++) begin
      if (issue_valid && message_number_control == 2'd0) n_acc++;
      cyc();
    end
    check("t4_issue_count", 32'(n_acc), 15);
    check("t4_seq", 32'(issue_seq), 15);
    check("t4_ovf_sticky", 32'(pend_overflow), 32'h1);
    check("t4_busy", 32'(busy), 0);

    // enable gating
    do_reset();
    enable = 1'b0;
    req = 4'b1010;
    cyc(); req = '0;
    cyc(); cyc(); cyc();
    check("t5_no_issue", 32'(issue_valid), 0);
    check("t5_busy", 32'(busy), 1);
    enable = 1'b1;
    cyc();
    check("t5_first_valid", 32'(issue_valid), 1);
    check("t5_first_ctrl", 32'(message_number_control), 1);
    cyc();
    check("t5_second_ctrl", 32'(message_number_control), 3);
    check("t5_second_seq", 32'(issue_seq), 1);
    cyc();
    check("t5_idle", 32'(issue_valid), 0);
    ready = 1'b0;
    req = 4'b0001;
    cyc(); req = '0;
    cyc();
    check("t5_pres_valid", 32'(issue_valid), 1);
    enable = 1'b0;
    cyc(); cyc(); cyc();
    check("t5_held_valid", 32'(issue_valid), 1);
    check("t5_held_ctrl", 32'(message_number_control), 0);
    check("t5_held_seq", 32'(issue_seq), 2);
    ready = 1'b1;
    cyc();
    check("t5_released", 32'(issue_valid), 0);
    check("t5_seq_after", 32'(issue_seq), 3);
    enable = 1'b1;

    // Reset mid-issue
    do_reset();
    ready = 1'b0;
    req = 4'b1110;
    cyc(); req = '0;
    cyc();
    check("t6_pre_ctrl", 32'(message_number_control), 1);
    check("t6_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_valid", 32'(issue_valid), 0);
    check("t6_ctrl", 32'(message_number_control), 0);
    check("t6_seq", 32'(issue_seq), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_ovf", 32'(pend_overflow), 0);

    // Sequence counter wrap via continuous traffic on source 0
    do_reset();
    ready = 1'b1;
    req = 4'b0001;
    exp_seq = 0;
    done = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      cyc();
      if (issue_valid && exp_seq == 1000) check("t7_seq_mid", 32'(issue_seq), 1000);
      if (issue_valid && exp_seq == 65535) begin
        check("t7_seq_max", 32'(issue_seq), 65535);
        req = '0;
        cyc();
        check("t7_seq_wrap", 32'(issue_seq), 0);
        done = 1'b1;
      end else if (issue_valid) begin
        exp_seq++;
      end
    end
    if (!done) check("t7_timeout", 0, 1);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage2_message_scheduler.md
Name: stage2_message_scheduler

Overview:
- Round-robin scheduler that generates the message_number_control code for the stage-2 message-number lookup.
- Four message sources raise single-cycle request pulses. Each pulse is counted per source.
- The scheduler issues one control code per granted request to the downstream stage over a valid/ready handshake, and tags each issue with a running sequence number.

Parameters:
- CTRL_W, 2, width of message_number_control; equals the lookup control width.
- NUM_REQ, 4, number of request sources; fixed at 2**CTRL_W.
- CNT_W, 4, width of each per-source pending counter; saturates at 2**CNT_W-1.
- SEQ_W, 16, width of the issue sequence counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  when low, no new grants are made.
- req  in  NUM_REQ  per-source request pulse; each cycle high counts as one request.
- ready  in  1  downstream accepts the current issue when ready and issue_valid are both high.
- message_number_control  out  CTRL_W  granted source index (0..3); drives the lookup control input.
- issue_valid  out  1  an issue is presented.
- issue_seq  out  SEQ_W  sequence number of the presented issue.
- pend_overflow  out  NUM_REQ  sticky per-source flag: a request was lost at saturation.
- busy  out  1  high when issue_valid is high or any pending counter is nonzero.

Behaviour:
- Reset (rst high at a clock edge) sets:
  - all pending counters = 0;
  - state = IDLE;
  - issue_valid = 0;
  - message_number_control = 0;
  - issue_seq = 0;
  - pend_overflow = 0;
  - last_grant = NUM_REQ-1, so source 0 wins first.
- Reset mid-issue drops the in-flight issue with no accept. rst overrides all other inputs.
- Pending counters, per source i:
  - +1 when req[i] is high;
  - -1 when i is granted and the issue is accepted;
  - both in the same cycle: counter unchanged.
  - At 2**CNT_W-1, an increment without a simultaneous decrement is dropped and sets pend_overflow[i]. The flag clears only on reset.
- Handshake and outputs:
  - accept = issue_valid & ready.
  - message_number_control, issue_valid and issue_seq are registered.
  - message_number_control and issue_seq hold stable while issue_valid=1 and not accepted.
  - message_number_control keeps its last value when issue_valid=0.
- Arbitration:
  - Candidates are sources with effective count nonzero. Effective count = registered count minus 1 if the source is the one being accepted this cycle.
  - req pulses of the current cycle are not candidates; they become visible the next cycle.
  - Winner = first candidate searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
- State machine (2 states):
  - IDLE: if enable and a candidate exists, load message_number_control=winner, set issue_valid=1, go to ISSUE. Otherwise stay.
  - ISSUE, no accept: hold all outputs.
  - ISSUE, accept:
    - last_grant <= message_number_control;
    - issue_seq <= issue_seq+1, wrapping 2**SEQ_W-1 -> 0;
    - decrement the granted counter.
    - If enable and a candidate exists: load the new winner, keep issue_valid=1 and stay in ISSUE (back-to-back, one issue per cycle).
    - Otherwise: issue_valid=0, go to IDLE.
  - enable low does not withdraw an issue already presented; it only blocks new grants.
- Latency:
  - A req pulse at edge N makes the counter nonzero after N.
  - issue_valid rises after edge N+1, provided the source wins and the scheduler was idle.
- The first issue after reset has issue_seq=0.

Test Plan:
- Reset, enable=1, ready=1, single req[2] pulse at cycle 5 -> counter[2]=1 at cycle 6; issue_valid=1, control=2, seq=0 at cycle 7; issue_valid=0 at cycle 8; busy=0.
- req=4'b1111 for one cycle, ready=1 -> four consecutive cycles of issue_valid with control 0,1,2,3 and seq 0..3, then idle.
- req[1] pulsed 3 times, ready=0 for 10 cycles -> control=1 held with seq unchanged. Then ready=1 -> three back-to-back accepts, control=1 each, seq increments by 1 each.
- req[0] held high 20 cycles, ready=0 -> counter[0] saturates at 15 and pend_overflow[0]=1 (stays 1). Release ready -> exactly 15 issues for source 0.
- enable=0 with pending requests on sources 1 and 3 -> no issue. enable=1 -> issues 1 then 3. Drop enable while issue_valid=1 and ready=0 -> issue held until ready.
- rst during ISSUE with counters nonzero -> next cycle all outputs 0 and counters 0. Also preload issue_seq to 65535 via traffic -> the next accept wraps it to 0.
